regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between two result sources:
  - pipeline writeback (WB), which has priority;
  - the multi-cycle M-extension unit (MUL/DIV), which uses a valid/ready handshake and a 1-entry pending buffer.
- Keeps a scoreboard of destination registers with M-unit results in flight, and gives decode a hazard/stall signal.
- Sits between the WB stage, the M unit and the register file write inputs.

Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers
- AW, 5, register address width
- STARVE_LIMIT, 4, consecutive cycles a pending M result may lose arbitration before WB is stalled

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- wb_valid  input  1  WB stage has a result this cycle
- wb_rd  input  AW  WB destination
- wb_data  input  XLEN  WB result
- wb_stall  output  1  WB result not consumed; pipeline holds WB
- m_valid  input  1  M unit result valid
- m_rd  input  AW  M unit destination
- m_data  input  XLEN  M unit result
- m_ready  output  1  M result accepted when m_valid&&m_ready
- iss_valid  input  1  M-unit instruction issued this cycle
- iss_rd  input  AW  its destination
- dec_rs1, dec_rs2, dec_rd  input  AW each  decode-stage operands
- hazard  output  1  decode must stall
- rf_we  output  1  register file write enable
- rf_waddr  output  AW  write address
- rf_wdata  output  XLEN  write data

Behaviour:
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, wb_stall=0.
  - Pending buffer empty, starve counter 0, all busy bits 0.
  - m_ready=1 after reset.
- Write-port outputs are registered. A source selected in cycle N appears on rf_* in cycle N+1, and the register file commits at the end of N+1.
- Any selected write with rd=0 produces rf_we=0. x0 is never busy.
- m_ready = !pend_valid (combinational). An accepted M result goes straight to the port if WB is idle; otherwise it goes to the pending buffer.
- States:
  - IDLE: no pending entry. WB wins the port. An M result accepted while WB writes goes to PEND.
  - PEND:
    - Buffer drains in the first cycle with no effective WB write, then go to IDLE.
    - Each cycle it loses, the starve counter increments.
    - When the counter reaches STARVE_LIMIT, go to STARVE.
  - STARVE:
    - wb_stall=1 (registered; asserted the cycle after entry).
    - wb_valid is ignored, and the pipeline must hold its WB data.
    - Buffer drains this cycle, then go to IDLE.
    - wb_stall=0 the cycle after the drain; counter resets.
- Same-cycle priority when both are present: pending buffer > WB in STARVE; WB > pending buffer > direct M in IDLE/PEND.
- Scoreboard:
  - iss_valid with iss_rd!=0 sets busy[iss_rd].
  - busy[rd] clears on the clock edge at which the M write for rd commits, i.e. the end of the cycle with rf_we=1 from an M source.
  - If set and clear target the same rd in the same cycle, set wins.
- hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd] (WAW). Combinational.
- Reset mid-operation discards the pending entry and clears all busy bits and the starve counter. No write is emitted after reset.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds ports fwd1_hit/fwd2_hit (1-bit output) and fwd1_data/fwd2_data (XLEN output).
  - fwdN_hit = rf_we && rf_waddr==dec_rsN && dec_rsN!=0, with fwdN_data = rf_wdata.
  - hazard ignores a busy bit whose register equals rf_waddr while rf_we=1, so decode proceeds one cycle earlier.
- Undefined: the ports are absent and hazard is the pure busy-bit OR.

Test Plan:
- Reset, then wb_valid=1, wb_rd=5, wb_data=0x1234 for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; the cycle after, rf_we=0.
- wb_rd=0, wb_data=0xFFFF -> rf_we stays 0.
- Issue rd=7 -> hazard=1 for dec_rs1=7. Then m_valid with rd=7, data=0xAB and WB idle -> rf write (7, 0xAB) one cycle later; hazard=0 the cycle after that write (without WB_BYPASS_EN), or during it (with WB_BYPASS_EN, fwd1_hit=1, fwd1_data=0xAB).
- M result (rd=3, 0x11) collides with a WB write (rd=4, 0x22) -> rf writes (4, 0x22) then (3, 0x11); m_ready=0 while pending.
- Pending M result with WB writing every cycle and STARVE_LIMIT=4 -> wb_stall=1 after 4 lost cycles; the next write is the pending M result; wb_stall=0 afterwards and the held WB result is written next.
- Assert reset while PEND with busy[9]=1 -> m_ready=1, hazard=0 for rs1=9, and no rf_we follows.

Source files
------------

// File: rtl/regfile_write_scheduler_if.sv
// Signal bundle around regfile_write_scheduler: WB, M unit, issue/decode and register-file write port.
// The forwarding signals exist only when WB_BYPASS_EN is defined.
interface regfile_write_scheduler_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            wb_valid;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_stall;
   logic            m_valid;
   logic [AW-1:0]   m_rd;
   logic [XLEN-1:0] m_data;
   logic            m_ready;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic [AW-1:0]   dec_rs1;
   logic [AW-1:0]   dec_rs2;
   logic [AW-1:0]   dec_rd;
   logic            hazard;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
`ifdef WB_BYPASS_EN
   logic            fwd1_hit;
   logic            fwd2_hit;
   logic [XLEN-1:0] fwd1_data;
   logic [XLEN-1:0] fwd2_data;
`endif

   // master is the scheduler itself; slave is the pipeline, M unit and register file around it
`ifdef WB_BYPASS_EN
   modport master (
      input  wb_valid, wb_rd, wb_data, m_valid, m_rd, m_data, iss_valid, iss_rd,
             dec_rs1, dec_rs2, dec_rd,
      output wb_stall, m_ready, hazard, rf_we, rf_waddr, rf_wdata,
             fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );
   modport slave (
      output wb_valid, wb_rd, wb_data, m_valid, m_rd, m_data, iss_valid, iss_rd,
             dec_rs1, dec_rs2, dec_rd,
      input  wb_stall, m_ready, hazard, rf_we, rf_waddr, rf_wdata,
             fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
   );
`else
   modport master (
      input  wb_valid, wb_rd, wb_data, m_valid, m_rd, m_data, iss_valid, iss_rd,
             dec_rs1, dec_rs2, dec_rd,
      output wb_stall, m_ready, hazard, rf_we, rf_waddr, rf_wdata
   );
   modport slave (
      output wb_valid, wb_rd, wb_data, m_valid, m_rd, m_data, iss_valid, iss_rd,
             dec_rs1, dec_rs2, dec_rd,
      input  wb_stall, m_ready, hazard, rf_we, rf_waddr, rf_wdata
   );
`endif
endinterface

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port arbiter: WB has priority, M results wait in a 1-entry buffer with starvation
// protection, and a scoreboard flags M destinations in flight. Define WB_BYPASS_EN for write-port forwarding.
module regfile_write_scheduler #(
   parameter int XLEN         = 32,
   parameter int NREG         = 32,
   parameter int AW           = 5,
   parameter int STARVE_LIMIT = 4
) (
   input logic                       clk,
   input logic                       reset,
   regfile_write_scheduler_if.master bus
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, PEND, STARVE} state_t;

   state_t          state;
   logic            pend_valid;
   logic [AW-1:0]   pend_rd;
   logic [XLEN-1:0] pend_data;
   logic [CW-1:0]   starve_cnt;
   logic            wb_stall_q;
   logic            rf_we_q;
   logic            rf_from_m;
   logic [AW-1:0]   rf_waddr_q;
   logic [XLEN-1:0] rf_wdata_q;
   logic [NREG-1:0] busy;

   logic            wb_eff;
   logic            m_acc;
   logic            sel_valid;
   logic            sel_m;
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_data;
   logic [NREG-1:0] busy_eff;

   // A WB write to x0 never occupies the port; while starving, WB is ignored and held by the pipeline.
   assign wb_eff      = bus.wb_valid && (bus.wb_rd != '0) && (state != STARVE);
   assign m_acc       = bus.m_valid && !pend_valid;
   assign bus.m_ready = !pend_valid;

   always_comb begin
      sel_valid = 1'b0;
      sel_m     = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (state == STARVE) begin
         sel_valid = 1'b1;
         sel_m     = 1'b1;
         sel_rd    = pend_rd;
         sel_data  = pend_data;
      end else if (wb_eff) begin
         sel_valid = 1'b1;
         sel_rd    = bus.wb_rd;
         sel_data  = bus.wb_data;
      end else if (pend_valid) begin
         sel_valid = 1'b1;
         sel_m     = 1'b1;
         sel_rd    = pend_rd;
         sel_data  = pend_data;
      end else if (m_acc) begin
         sel_valid = 1'b1;
         sel_m     = 1'b1;
         sel_rd    = bus.m_rd;
         sel_data  = bus.m_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pend_valid <= 1'b0;
         pend_rd    <= '0;
         pend_data  <= '0;
         starve_cnt <= '0;
         wb_stall_q <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_from_m  <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q   <= sel_valid && (sel_rd != '0);
         rf_from_m <= sel_m;
         if (sel_valid) begin
            rf_waddr_q <= sel_rd;
            rf_wdata_q <= sel_data;
         end
         case (state)
            IDLE: begin
               if (m_acc && wb_eff) begin
                  pend_valid <= 1'b1;
                  pend_rd    <= bus.m_rd;
                  pend_data  <= bus.m_data;
                  starve_cnt <= '0;
                  state      <= PEND;
               end
            end
            PEND: begin
               if (!wb_eff) begin
                  pend_valid <= 1'b0;
                  starve_cnt <= '0;
                  state      <= IDLE;
               end else begin
                  starve_cnt <= starve_cnt + 1'b1;
                  if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
                     wb_stall_q <= 1'b1;
                     state      <= STARVE;
                  end
               end
            end
            STARVE: begin
               pend_valid <= 1'b0;
               starve_cnt <= '0;
               wb_stall_q <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Busy clears when an M write commits (rf_we from an M source); a same-cycle issue to that rd wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (bus.iss_valid && (bus.iss_rd == AW'(i)) && (i != 0))
               busy[i] <= 1'b1;
            else if (rf_we_q && rf_from_m && (rf_waddr_q == AW'(i)))
               busy[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      busy_eff = busy;
`ifdef WB_BYPASS_EN
      if (rf_we_q)
         busy_eff[rf_waddr_q] = 1'b0;
`endif
   end

   assign bus.hazard   = busy_eff[bus.dec_rs1] | busy_eff[bus.dec_rs2] | busy_eff[bus.dec_rd];
   assign bus.wb_stall = wb_stall_q;
   assign bus.rf_we    = rf_we_q;
   assign bus.rf_waddr = rf_waddr_q;
   assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_BYPASS_EN
   assign bus.fwd1_hit  = rf_we_q && (rf_waddr_q == bus.dec_rs1) && (bus.dec_rs1 != '0);
   assign bus.fwd2_hit  = rf_we_q && (rf_waddr_q == bus.dec_rs2) && (bus.dec_rs2 != '0);
   assign bus.fwd1_data = rf_wdata_q;
   assign bus.fwd2_data = rf_wdata_q;
`endif
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: vector table, starvation and reset sequences, then random traffic
// against a reference model of the arbitration rules. Also covers WB_BYPASS_EN when defined.
module tb_regfile_write_scheduler;
   localparam int STARVE_LIMIT = 4;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        wb_valid;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        m_valid;
      logic [4:0]  m_rd;
      logic [31:0] m_data;
      logic        iss_valid;
      logic [4:0]  iss_rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } stim_t;

   typedef struct {
      stim_t       in;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mready;
      logic        hazard;
      logic        stall;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   model_ready = 1'b0;

   regfile_write_scheduler_if #(.XLEN(32), .AW(5)) bus ();

   regfile_write_scheduler #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the port this cycle, one optional waiting M result, a loss count,
   // and one busy flag per register. exp_* is what the port must show during the next cycle.
   bit          mdl_pend = 1'b0;
   logic [4:0]  mdl_pend_rd = '0;
   logic [31:0] mdl_pend_data = '0;
   int          mdl_losses = 0;
   bit          mdl_stall = 1'b0;
   bit          mdl_busy [32];
   bit          exp_we = 1'b0;
   bit          exp_from_m = 1'b0;
   logic [4:0]  exp_addr = '0;
   logic [31:0] exp_data = '0;

   task automatic modelStep();
      bit          own;
      bit          from_m;
      logic [4:0]  w_rd;
      logic [31:0] w_data;
      bit          m_take;
      bit          wb_real;
      if (reset) begin
         mdl_pend   = 1'b0;
         mdl_losses = 0;
         mdl_stall  = 1'b0;
         exp_we     = 1'b0;
         exp_from_m = 1'b0;
         for (int r = 0; r < 32; r++) mdl_busy[r] = 1'b0;
         return;
      end
      own     = 1'b0;
      from_m  = 1'b0;
      w_rd    = '0;
      w_data  = '0;
      m_take  = bus.m_valid && !mdl_pend;
      wb_real = bus.wb_valid && (bus.wb_rd != 5'd0) && !mdl_stall;
      if (mdl_stall) begin
         own = 1'b1; from_m = 1'b1; w_rd = mdl_pend_rd; w_data = mdl_pend_data;
         mdl_pend = 1'b0; mdl_losses = 0; mdl_stall = 1'b0;
      end else if (wb_real) begin
         own = 1'b1; w_rd = bus.wb_rd; w_data = bus.wb_data;
         if (mdl_pend) begin
            mdl_losses++;
            if (mdl_losses == STARVE_LIMIT) mdl_stall = 1'b1;
         end else if (m_take) begin
            mdl_pend = 1'b1; mdl_pend_rd = bus.m_rd; mdl_pend_data = bus.m_data; mdl_losses = 0;
         end
      end else if (mdl_pend) begin
         own = 1'b1; from_m = 1'b1; w_rd = mdl_pend_rd; w_data = mdl_pend_data;
         mdl_pend = 1'b0; mdl_losses = 0;
      end else if (m_take) begin
         own = 1'b1; from_m = 1'b1; w_rd = bus.m_rd; w_data = bus.m_data;
      end
      if (exp_we && exp_from_m) mdl_busy[exp_addr] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 5'd0) mdl_busy[bus.iss_rd] = 1'b1;
      exp_we     = own && (w_rd != 5'd0);
      exp_from_m = from_m;
      exp_addr   = w_rd;
      exp_data   = w_data;
   endtask

   function automatic bit regBlocked(input logic [4:0] r);
      if (BYP && exp_we && exp_addr == r) return 1'b0;
      return mdl_busy[r];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkModel();
      checkOutput("mdl rf_we", bus.rf_we, exp_we);
      if (exp_we) begin
         checkOutput("mdl rf_waddr", bus.rf_waddr, exp_addr);
         checkOutput("mdl rf_wdata", bus.rf_wdata, exp_data);
      end
      checkOutput("mdl m_ready", bus.m_ready, !mdl_pend);
      checkOutput("mdl wb_stall", bus.wb_stall, mdl_stall);
      checkOutput("mdl hazard", bus.hazard,
                  regBlocked(bus.dec_rs1) | regBlocked(bus.dec_rs2) | regBlocked(bus.dec_rd));
`ifdef WB_BYPASS_EN
      checkOutput("mdl fwd1_hit", bus.fwd1_hit, exp_we && exp_addr == bus.dec_rs1 && bus.dec_rs1 != 5'd0);
      checkOutput("mdl fwd2_hit", bus.fwd2_hit, exp_we && exp_addr == bus.dec_rs2 && bus.dec_rs2 != 5'd0);
      if (bus.fwd1_hit) checkOutput("mdl fwd1_data", bus.fwd1_data, exp_data);
      if (bus.fwd2_hit) checkOutput("mdl fwd2_data", bus.fwd2_data, exp_data);
`endif
   endtask

   task automatic applyStimulus(input stim_t s, input logic rst);
      reset         = rst;
      bus.wb_valid  = s.wb_valid;
      bus.wb_rd     = s.wb_rd;
      bus.wb_data   = s.wb_data;
      bus.m_valid   = s.m_valid;
      bus.m_rd      = s.m_rd;
      bus.m_data    = s.m_data;
      bus.iss_valid = s.iss_valid;
      bus.iss_rd    = s.iss_rd;
      bus.dec_rs1   = s.rs1;
      bus.dec_rs2   = s.rs2;
      bus.dec_rd    = s.rd;
   endtask

   task automatic cycleBegin(input stim_t s, input logic rst);
      @(negedge clk);
      applyStimulus(s, rst);
      #1;
      if (model_ready) checkModel();
   endtask

   function automatic stim_t st(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic iv, input logic [4:0] ird, input logic [4:0] r1);
      stim_t s;
      s.wb_valid = wv; s.wb_rd = wrd; s.wb_data = wd;
      s.m_valid = mv; s.m_rd = mrd; s.m_data = md;
      s.iss_valid = iv; s.iss_rd = ird;
      s.rs1 = r1; s.rs2 = 5'd0; s.rd = 5'd0;
      return s;
   endfunction

   function automatic vec_t vec(input stim_t s, input logic we, input logic [4:0] a, input logic [31:0] d,
                                input logic mr, input logic hz, input logic stl);
      vec_t v;
      v.in = s; v.we = we; v.addr = a; v.data = d; v.mready = mr; v.hazard = hz; v.stall = stl;
      return v;
   endfunction

   initial begin
      vec_t  tbl [12];
      stim_t idle;
      stim_t s;
      bit    hold_wb;
      logic  rst;

      idle = st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      for (int r = 0; r < 32; r++) mdl_busy[r] = 1'b0;
      applyStimulus(idle, 1'b1);
      repeat (3) begin
         cycleBegin(idle, 1'b1);
         modelStep();
      end
      model_ready = 1'b1;

      tbl[0]  = vec(idle, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      tbl[1]  = vec(st(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      tbl[2]  = vec(st(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0), 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0);
      tbl[3]  = vec(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      tbl[4]  = vec(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
      tbl[5]  = vec(st(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAB, 1'b0, 5'd0, 5'd7), 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
      tbl[6]  = vec(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7), 1'b1, 5'd7, 32'hAB, 1'b1, !BYP, 1'b0);
      tbl[7]  = vec(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      tbl[8]  = vec(st(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      tbl[9]  = vec(idle, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0, 1'b0);
      tbl[10] = vec(idle, 1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 1'b0);
      tbl[11] = vec(idle, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         cycleBegin(tbl[i].in, 1'b0);
         checkOutput($sformatf("tbl%0d rf_we", i), bus.rf_we, tbl[i].we);
         if (tbl[i].we) begin
            checkOutput($sformatf("tbl%0d rf_waddr", i), bus.rf_waddr, tbl[i].addr);
            checkOutput($sformatf("tbl%0d rf_wdata", i), bus.rf_wdata, tbl[i].data);
         end
         checkOutput($sformatf("tbl%0d m_ready", i), bus.m_ready, tbl[i].mready);
         checkOutput($sformatf("tbl%0d hazard", i), bus.hazard, tbl[i].hazard);
         checkOutput($sformatf("tbl%0d wb_stall", i), bus.wb_stall, tbl[i].stall);
`ifdef WB_BYPASS_EN
         if (i == 6) begin
            checkOutput("tbl6 fwd1_hit", bus.fwd1_hit, 1'b1);
            checkOutput("tbl6 fwd1_data", bus.fwd1_data, 32'hAB);
         end
`endif
         modelStep();
      end

      // Starvation: M result parked behind WB, WB keeps writing until the pending entry forces a stall.
      cycleBegin(st(1'b1, 5'd10, 32'hA0, 1'b1, 5'd12, 32'h5A, 1'b0, 5'd0, 5'd0), 1'b0);
      modelStep();
      for (int k = 1; k <= 4; k++) begin
         cycleBegin(st(1'b1, 5'(10 + k), 32'(32'hA0 + k), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0), 1'b0);
         checkOutput("starve m_ready", bus.m_ready, 1'b0);
         checkOutput("starve no stall yet", bus.wb_stall, 1'b0);
         checkOutput("starve wb addr", bus.rf_waddr, 5'(9 + k));
         modelStep();
      end
      s = st(1'b1, 5'd15, 32'hAF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      cycleBegin(s, 1'b0);
      checkOutput("starve stall", bus.wb_stall, 1'b1);
      checkOutput("starve last wb", bus.rf_waddr, 5'd14);
      modelStep();
      cycleBegin(s, 1'b0);
      checkOutput("starve stall drop", bus.wb_stall, 1'b0);
      checkOutput("starve m we", bus.rf_we, 1'b1);
      checkOutput("starve m addr", bus.rf_waddr, 5'd12);
      checkOutput("starve m data", bus.rf_wdata, 32'h5A);
      checkOutput("starve m_ready back", bus.m_ready, 1'b1);
      modelStep();
      cycleBegin(idle, 1'b0);
      checkOutput("starve held wb addr", bus.rf_waddr, 5'd15);
      checkOutput("starve held wb data", bus.rf_wdata, 32'hAF);
      modelStep();

      // Reset while an entry is pending and x9 is busy.
      cycleBegin(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0), 1'b0);
      modelStep();
      cycleBegin(st(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0), 1'b0);
      modelStep();
      cycleBegin(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9), 1'b1);
      checkOutput("rst pre m_ready", bus.m_ready, 1'b0);
      checkOutput("rst pre hazard", bus.hazard, 1'b1);
      modelStep();
      cycleBegin(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9), 1'b0);
      checkOutput("rst m_ready", bus.m_ready, 1'b1);
      checkOutput("rst hazard", bus.hazard, 1'b0);
      checkOutput("rst rf_we", bus.rf_we, 1'b0);
      modelStep();
      cycleBegin(st(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9), 1'b0);
      checkOutput("rst no drain", bus.rf_we, 1'b0);
      modelStep();

      // Random traffic; the WB stage holds its result through a stall cycle.
      s = idle;
      hold_wb = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!hold_wb) begin
            s.wb_valid = ($urandom_range(0, 3) != 0);
            s.wb_rd    = 5'($urandom_range(1, 31));
            s.wb_data  = $urandom;
         end
         s.m_valid   = ($urandom_range(0, 2) == 0);
         s.m_rd      = 5'($urandom_range(0, 31));
         s.m_data    = $urandom;
         s.iss_valid = ($urandom_range(0, 3) == 0);
         s.iss_rd    = 5'($urandom_range(0, 31));
         s.rs1       = 5'($urandom_range(0, 31));
         s.rs2       = 5'($urandom_range(0, 31));
         s.rd        = 5'($urandom_range(0, 31));
         rst         = ($urandom_range(0, 249) == 0);
         cycleBegin(s, rst);
         hold_wb = mdl_stall && !rst;
         modelStep();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
